// File: rtl/priority_encoder.sv
// Registered priority encoder: reports the index of the highest set bit of
// d_in one cycle later, with a valid flag to tell an all-zero request
// vector apart from a lone request at index 0.
// Optional build macro PE_MULTI_HOT_FLAG_EN adds a registered 'multi'
// output that flags two or more simultaneous requests.
module priority_encoder #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  d_in,
  output logic [OUT_W-1:0] a_out,
  output logic             valid
`ifdef PE_MULTI_HOT_FLAG_EN
  ,
  output logic             multi
`endif
);

  logic [OUT_W-1:0] w_idx;
  logic             w_any;
  logic [OUT_W-1:0] r_idx;
  logic             r_valid;

  // Ascending scan: the last set bit seen is the highest, so MSB wins.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (d_in[i]) w_idx = OUT_W'(i);
    end
  end

  assign w_any = |d_in;

  // Output registers; reset clears them and overrides the request vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_idx   <= w_idx;
      r_valid <= w_any;
    end
  end

  assign a_out = r_idx;
  assign valid = r_valid;

`ifdef PE_MULTI_HOT_FLAG_EN
  logic w_seen;
  logic w_multi;
  logic r_multi;

  // A second set bit after one already seen means multi-hot.
  always_comb begin
    w_seen  = 1'b0;
    w_multi = 1'b0;
    for (int i = 0; i < IN_W; i++) begin
      if (d_in[i]) begin
        if (w_seen) w_multi = 1'b1;
        w_seen = 1'b1;
      end
    end
  end

  // Multi-hot flag register, same latency as a_out/valid.
  always_ff @(posedge clk) begin
    if (rst) r_multi <= 1'b0;
    else     r_multi <= w_multi;
  end

  assign multi = r_multi;
`endif

endmodule

// File: tb/tb_priority_encoder.sv
// Bench for priority_encoder (8->3). Inputs change on the falling edge,
// outputs are sampled 1 time unit after the rising edge.
module tb_priority_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] d_in;
  logic [2:0] a_out;
  logic       valid;
`ifdef PE_MULTI_HOT_FLAG_EN
  logic       multi;
`endif

  int checks = 0;
  int errors = 0;

  priority_encoder #(.IN_W(8), .OUT_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .d_in  (d_in),
    .a_out (a_out),
    .valid (valid)
`ifdef PE_MULTI_HOT_FLAG_EN
    ,
    .multi (multi)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: highest set bit = floor(log2(d)) = clog2(d+1)-1.
  function automatic logic [2:0] ref_idx(input logic [7:0] d);
    if (d == 8'h00) return 3'd0;
    return 3'($clog2(int'(d) + 1) - 1);
  endfunction

  function automatic logic ref_valid(input logic [7:0] d);
    return d != 8'h00;
  endfunction

  function automatic logic ref_multi(input logic [7:0] d);
    return $countones(d) > 1;
  endfunction

  // Apply inputs at the falling edge, then move to just after the next rising edge.
  task automatic drive(input logic [7:0] d, input logic r);
    @(negedge clk);
    d_in = d;
    rst  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(8'hFF, 1'b1);
      checks++;
      if (a_out !== 3'd0) begin
        errors++; $display("FAIL reset_a_out cyc%0d got %0d want 0", k, a_out);
      end
      checks++;
      if (valid !== 1'b0) begin
        errors++; $display("FAIL reset_valid cyc%0d got %b want 0", k, valid);
      end
`ifdef PE_MULTI_HOT_FLAG_EN
      checks++;
      if (multi !== 1'b0) begin
        errors++; $display("FAIL reset_multi cyc%0d got %b want 0", k, multi);
      end
`endif
    end
  endtask

  task automatic test_walking_one();
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      d = 8'h01 << i;
      drive(d, 1'b0);
      checks++;
      if (a_out !== 3'(i)) begin
        errors++; $display("FAIL walk_a_out[%0d] got %0d want %0d", i, a_out, i);
      end
      checks++;
      if (valid !== 1'b1) begin
        errors++; $display("FAIL walk_valid[%0d] got %b want 1", i, valid);
      end
`ifdef PE_MULTI_HOT_FLAG_EN
      checks++;
      if (multi !== 1'b0) begin
        errors++; $display("FAIL walk_multi[%0d] got %b want 0", i, multi);
      end
`endif
    end
  endtask

  task automatic test_priority();
    drive(8'b1100_0000, 1'b0);
    checks++;
    if (a_out !== 3'd7) begin
      errors++; $display("FAIL prio_c0_a_out got %0d want 7", a_out);
    end
    checks++;
    if (valid !== 1'b1) begin
      errors++; $display("FAIL prio_c0_valid got %b want 1", valid);
    end
`ifdef PE_MULTI_HOT_FLAG_EN
    checks++;
    if (multi !== 1'b1) begin
      errors++; $display("FAIL prio_c0_multi got %b want 1", multi);
    end
`endif
    drive(8'b0001_0110, 1'b0);
    checks++;
    if (a_out !== 3'd4) begin
      errors++; $display("FAIL prio_16_a_out got %0d want 4", a_out);
    end
    checks++;
    if (valid !== 1'b1) begin
      errors++; $display("FAIL prio_16_valid got %b want 1", valid);
    end
  endtask

  task automatic test_zero();
    drive(8'h00, 1'b0);
    checks++;
    if (a_out !== 3'd0) begin
      errors++; $display("FAIL zero_a_out got %0d want 0", a_out);
    end
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL zero_valid got %b want 0", valid);
    end
`ifdef PE_MULTI_HOT_FLAG_EN
    checks++;
    if (multi !== 1'b0) begin
      errors++; $display("FAIL zero_multi got %b want 0", multi);
    end
`endif
  endtask

  task automatic test_latency();
    drive(8'h01, 1'b0);
    // New value presented; before the next rising edge the old result must hold.
    @(negedge clk);
    d_in = 8'h80;
    #2;
    checks++;
    if (a_out !== 3'd0 || valid !== 1'b1) begin
      errors++; $display("FAIL latency_before got %0d/%b want 0/1", a_out, valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (a_out !== 3'd7 || valid !== 1'b1) begin
      errors++; $display("FAIL latency_after got %0d/%b want 7/1", a_out, valid);
    end
  endtask

  task automatic test_reset_mid();
    drive(8'h80, 1'b0);
    drive(8'h80, 1'b1);
    checks++;
    if (a_out !== 3'd0 || valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_during got %0d/%b want 0/0", a_out, valid);
    end
    drive(8'h80, 1'b0);
    checks++;
    if (a_out !== 3'd7 || valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_after got %0d/%b want 7/1", a_out, valid);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       r;
    logic [2:0] ea;
    logic       ev;
    logic       em;
    for (int n = 0; n < 300; n++) begin
      d = 8'($urandom);
      if (n % 4 == 0) d = d & 8'($urandom);  // bias toward sparse vectors
      r = ($urandom_range(0, 19) == 0);
      ea = r ? 3'd0 : ref_idx(d);
      ev = r ? 1'b0 : ref_valid(d);
      em = r ? 1'b0 : ref_multi(d);
      drive(d, r);
      checks++;
      if (a_out !== ea || valid !== ev) begin
        errors++;
        $display("FAIL rand[%0d] d=%h rst=%b got %0d/%b want %0d/%b", n, d, r, a_out, valid, ea, ev);
      end
`ifdef PE_MULTI_HOT_FLAG_EN
      checks++;
      if (multi !== em) begin
        errors++; $display("FAIL rand_multi[%0d] d=%h got %b want %b", n, d, multi, em);
      end
`else
      if (em === 1'bx) $display("unexpected model state");
`endif
    end
  endtask

  initial begin
    rst  = 1'b1;
    d_in = 8'hFF;
    test_reset();
    test_walking_one();
    test_priority();
    test_zero();
    test_latency();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
